// File: rtl/cr_br_cond_if.sv
// cr_br_cond_if: branch request, CR scoreboard, CTR write and result signals for the branch-condition evaluator.
interface cr_br_cond_if #(parameter int CR_WIDTH = 32, parameter int CTR_WIDTH = 32);
  logic                 req_valid;
  logic                 req_ready;
  logic [0:4]           BO;
  logic [0:4]           BI;
  logic [0:CR_WIDTH-1]  CR;
  logic [0:7]           pend_set;
  logic [0:7]           pend_clr;
  logic                 CTRWr;
  logic [0:CTR_WIDTH-1] CTRWd;
  logic                 res_valid;
  logic                 taken;
  logic [0:CTR_WIDTH-1] CTR;
  modport master (
    output req_valid, BO, BI, CR, pend_set, pend_clr, CTRWr, CTRWd,
    input  req_ready, res_valid, taken, CTR
  );
  modport slave (
    input  req_valid, BO, BI, CR, pend_set, pend_clr, CTRWr, CTRWd,
    output req_ready, res_valid, taken, CTR
  );
endinterface

// File: rtl/cr_br_cond.sv
// cr_br_cond: evaluates BO/BI branch conditions against CR and CTR, with a per-field pending-write stall.
module cr_br_cond #(
  parameter int CR_WIDTH  = 32,
  parameter int CTR_WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  cr_br_cond_if.slave br
);
  logic [0:CR_WIDTH-1]  cr;
  logic [0:CTR_WIDTH-1] ctr_q, ctr_d, ctr_dec;
  logic [0:7]           pend_q, pend_d;
  logic                 res_valid_q, res_valid_d;
  logic                 taken_q, taken_d;
  logic [2:0]           fld;
  logic                 blocked, accept, ctr_ok, cond_ok;
  logic                 unused_hint;
  assign cr          = br.CR;
  assign unused_hint = br.BO[4];
  assign fld         = br.BI[0:2];
  // Field n lives at pend bit 7-n; only the registered scoreboard is consulted.
  assign blocked      = ~br.BO[0] & pend_q[3'd7 - fld];
  assign br.req_ready = ~blocked & ~br.CTRWr;
  assign accept       = br.req_valid & br.req_ready;
  always_comb begin
    ctr_dec     = br.BO[2] ? ctr_q : ctr_q - 1'b1;
    ctr_ok      = br.BO[2] | ((ctr_dec != '0) ^ br.BO[3]);
    cond_ok     = br.BO[0] | (cr[br.BI] == br.BO[1]);
    ctr_d       = br.CTRWr ? br.CTRWd : (accept ? ctr_dec : ctr_q);
    pend_d      = (pend_q & ~br.pend_clr) | br.pend_set;
    taken_d     = accept ? (ctr_ok & cond_ok) : taken_q;
    res_valid_d = accept;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr_q       <= '0;
      pend_q      <= '0;
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
    end else begin
      ctr_q       <= ctr_d;
      pend_q      <= pend_d;
      res_valid_q <= res_valid_d;
      taken_q     <= taken_d;
    end
  end
  assign br.res_valid = res_valid_q;
  assign br.taken     = taken_q;
  assign br.CTR       = ctr_q;
endmodule

// File: tb/tb_cr_br_cond.sv
// tb_cr_br_cond: directed vector table plus hand sequences for scoreboard stalls and reset.
module tb_cr_br_cond;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  cr_br_cond_if ifc ();
  cr_br_cond dut (.clk(clk), .rst_n(rst_n), .br(ifc.slave));
  typedef struct {
    logic        wr;
    logic [31:0] wd;
    logic        vld;
    logic [4:0]  bo;
    logic [4:0]  bi;
    logic [31:0] cr;
    logic [7:0]  ps;
    logic [7:0]  pc;
    logic        rdy;
    logic        rv;
    logic        tk;
    logic [31:0] ctr;
  } vec_t;
  function automatic vec_t mk(logic wr, logic [31:0] wd, logic vld, logic [4:0] bo, logic [4:0] bi,
                              logic [31:0] cr, logic [7:0] ps, logic [7:0] pc,
                              logic rdy, logic rv, logic tk, logic [31:0] ctr);
    vec_t v;
    v.wr = wr; v.wd = wd; v.vld = vld; v.bo = bo; v.bi = bi; v.cr = cr; v.ps = ps; v.pc = pc;
    v.rdy = rdy; v.rv = rv; v.tk = tk; v.ctr = ctr;
    return v;
  endfunction
  function automatic void chk(string nm, string what, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s %s: got %h expected %h", nm, what, act, exp);
    end
  endfunction
  task automatic drive(input vec_t v);
    ifc.CTRWr = v.wr; ifc.CTRWd = v.wd; ifc.req_valid = v.vld; ifc.BO = v.bo; ifc.BI = v.bi;
    ifc.CR = v.cr; ifc.pend_set = v.ps; ifc.pend_clr = v.pc;
  endtask
  task automatic step(input vec_t v, input string nm);
    drive(v);
    #1;
    chk(nm, "req_ready", {31'd0, ifc.req_ready}, {31'd0, v.rdy});
    @(posedge clk);
    #1;
    chk(nm, "res_valid", {31'd0, ifc.res_valid}, {31'd0, v.rv});
    chk(nm, "taken", {31'd0, ifc.taken}, {31'd0, v.tk});
    chk(nm, "CTR", ifc.CTR, v.ctr);
  endtask
  vec_t tbl[12];
  initial begin
    tbl[0]  = mk(0, 0, 1, 5'b10100, 5'd0, 32'h0,        0, 0, 1, 1, 1, 32'h0);
    tbl[1]  = mk(1, 2, 1, 5'b10000, 5'd0, 32'h0,        0, 0, 0, 0, 1, 32'h2);
    tbl[2]  = mk(0, 0, 1, 5'b10000, 5'd0, 32'h0,        0, 0, 1, 1, 1, 32'h1);
    tbl[3]  = mk(0, 0, 1, 5'b10000, 5'd0, 32'h0,        0, 0, 1, 1, 0, 32'h0);
    tbl[4]  = mk(0, 0, 1, 5'b10000, 5'd0, 32'h0,        0, 0, 1, 1, 1, 32'hFFFFFFFF);
    tbl[5]  = mk(0, 0, 0, 5'b10000, 5'd0, 32'h0,        0, 0, 1, 0, 1, 32'hFFFFFFFF);
    tbl[6]  = mk(0, 0, 1, 5'b01100, 5'd2, 32'h20000000, 0, 0, 1, 1, 1, 32'hFFFFFFFF);
    tbl[7]  = mk(0, 0, 1, 5'b00100, 5'd2, 32'h20000000, 0, 0, 1, 1, 0, 32'hFFFFFFFF);
    tbl[8]  = mk(0, 0, 1, 5'b10010, 5'd0, 32'h0,        0, 0, 1, 1, 0, 32'hFFFFFFFE);
    tbl[9]  = mk(1, 1, 0, 5'b10010, 5'd0, 32'h0,        0, 0, 0, 0, 0, 32'h1);
    tbl[10] = mk(0, 0, 1, 5'b10010, 5'd0, 32'h0,        0, 0, 1, 1, 1, 32'h0);
    tbl[11] = mk(0, 0, 1, 5'b01000, 5'd2, 32'h20000000, 0, 0, 1, 1, 1, 32'hFFFFFFFF);
    drive(mk(0, 0, 0, 5'b0, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", "res_valid", {31'd0, ifc.res_valid}, 32'd0);
    chk("reset", "taken", {31'd0, ifc.taken}, 32'd0);
    chk("reset", "CTR", ifc.CTR, 32'd0);
    chk("reset", "req_ready", {31'd0, ifc.req_ready}, 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i));
    // Field 0 pending: unconditional-on-CR request passes, conditional one stalls until clear retires.
    step(mk(0, 0, 0, 5'b00100, 5'd1, 32'h0, 8'h01, 0, 1, 0, 1, 32'hFFFFFFFF), "pset_f0");
    step(mk(0, 0, 1, 5'b10100, 5'd1, 32'h0, 0, 0, 1, 1, 1, 32'hFFFFFFFF), "bo0_bypass");
    step(mk(0, 0, 1, 5'b00100, 5'd8, 32'h0, 0, 0, 1, 1, 1, 32'hFFFFFFFF), "other_field");
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 1, 5'b00100, 5'd1, 32'h0, 0, 0, 0, 0, 1, 32'hFFFFFFFF), $sformatf("stall_f0_%0d", i));
    step(mk(0, 0, 1, 5'b00100, 5'd1, 32'h0, 0, 8'h01, 0, 0, 1, 32'hFFFFFFFF), "clr_cycle");
    step(mk(0, 0, 1, 5'b00100, 5'd1, 32'h40000000, 0, 0, 1, 1, 0, 32'hFFFFFFFF), "after_clr");
    // Set and clear together on field 7: set wins.
    step(mk(0, 0, 0, 5'b00100, 5'd28, 32'h0, 8'h80, 8'h80, 1, 0, 0, 32'hFFFFFFFF), "set_clr_f7");
    step(mk(0, 0, 1, 5'b00100, 5'd28, 32'h0, 0, 0, 0, 0, 0, 32'hFFFFFFFF), "stall_f7_a");
    step(mk(0, 0, 1, 5'b00100, 5'd28, 32'h0, 0, 0, 0, 0, 0, 32'hFFFFFFFF), "stall_f7_b");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_stall", "res_valid", {31'd0, ifc.res_valid}, 32'd0);
    chk("rst_stall", "taken", {31'd0, ifc.taken}, 32'd0);
    chk("rst_stall", "CTR", ifc.CTR, 32'd0);
    rst_n = 1'b1;
    step(mk(0, 0, 1, 5'b00100, 5'd28, 32'h0, 0, 0, 1, 1, 1, 32'h0), "post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cr_br_cond.md
# cr_br_cond

Branch-condition evaluator: the read side of the condition register. It accepts a conditional-branch request (BO, BI), reads the selected CR bit, and owns the 32-bit CTR, decrementing and testing it. It returns a registered taken/not-taken result one cycle later. A per-field pending-write scoreboard stalls requests whose CR field still has an in-flight write. It sits between decode/issue and the fetch redirect logic, alongside the CR write path.

## Interface
- `CR_WIDTH`, 32: CR width in bits.
- `CTR_WIDTH`, 32: CTR width in bits.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: branch request present.
- `req_ready` out 1: request accepted this cycle when high with `req_valid`.
- `BO` in [0:4]: branch options (PowerPC bit order, bit 0 = MSB).
- `BI` in [0:4]: CR bit index; `BI[0:2]` = field, `BI[3:4]` = bit within field.
- `CR` in [0:31]: current architected CR value.
- `pend_set` in [0:7]: CR write issued, field mask in hsel encoding (bit `7-n` = field n).
- `pend_clr` in [0:7]: CR write retired, same encoding.
- `CTRWr` in 1: external CTR write (mtctr).
- `CTRWd` in [0:31]: CTR write data.
- `res_valid` out 1: one-cycle pulse, result valid.
- `taken` out 1: branch taken; meaningful only while `res_valid` is high.
- `CTR` out [0:31]: current CTR value.

## Operation
- Scoreboard: 8-bit register `pend`.
  - Each cycle, `pend <= (pend & ~pend_clr) | pend_set`.
  - When a bit is both set and cleared in the same cycle, set wins.
- Field of request: `f = BI[0:2]`. The request is blocked when `BO[0]==0` and `pend[7-f]==1`. Only the registered `pend` is used; there is no same-cycle bypass of `pend_clr`.
- `req_ready = ~blocked & ~CTRWr`.
  - An mtctr cycle always stalls branches, so the two CTR writers never collide.
- On accept (`req_valid & req_ready`):
  - `ctr_next = BO[2] ? CTR : CTR - 1`. Modulo 2^32: 0 wraps to 0xFFFFFFFF.
  - `ctr_ok = BO[2] | ((ctr_next != 0) ^ BO[3])`.
  - `cond_ok = BO[0] | (CR[BI] == BO[1])`. The CR bit is indexed MSB-first, so `CR[0]` is CR0.LT.
  - `taken <= ctr_ok & cond_ok`; `res_valid <= 1`; `CTR <= ctr_next`.
  - `BO[4]` (prediction hint) is ignored.
- No accept: `res_valid <= 0`. `taken` holds its last value.
- `CTRWr`: `CTR <= CTRWd`, regardless of `req_valid`.
- Control states (implicit, two):
  - IDLE/ACCEPT: `req_ready` high.
  - STALL: `req_ready` low, caused by `blocked` or `CTRWr`.
  - STALL exits in the cycle after the causing `pend` bit clears, or when `CTRWr` drops.
  - Back-to-back accepts are allowed every cycle.
- The requester holds `req_valid`, `BO` and `BI` stable until accepted.

## Timing
- Reset values (`rst_n` low at a clock edge): `CTR=0`, `pend=0`, `res_valid=0`, `taken=0`.
  - `req_ready` is combinational and reads 1 after reset unless `CTRWr` is high.
- Reset mid-stall: the request and scoreboard are discarded; `res_valid` stays 0 the next cycle.
- Result latency: 1 cycle. Accept at edge N means `res_valid`/`taken` are valid in cycle N+1, and `CTR` shows the decremented value in cycle N+1.
- A second accept in cycle N+1 uses the already-updated CTR.
- Scoreboard latency:
  - `pend_set` in cycle N blocks requests from cycle N+1.
  - `pend_clr` in cycle N unblocks from cycle N+1.
  - The `CR` input must reflect the retired write by cycle N+1.
- `CTRWr` in cycle N: `req_ready=0` in cycle N; the new CTR is visible in cycle N+1.

## Test plan
- Reset, then bc `BO=10100` (always): accept in cycle 1, `res_valid=1` and `taken=1` in cycle 2, `CTR` stays 0.
- `CTRWr` with `CTRWd=2`, then three back-to-back bdnz (`BO=10000`):
  - `taken`: 1, 0, 1.
  - `CTR`: 1, 0, 0xFFFFFFFF.
  - `req_ready` is 0 during the `CTRWr` cycle.
- `CR=0x20000000` (CR0.EQ=1): `BO=01100 BI=00010` gives `taken=1`; `BO=00100 BI=00010` gives `taken=0`; CTR unchanged in both.
- `pend_set=0x01` (field 0), then a request with `BI=00001`:
  - `req_ready=0` until `pend_clr=0x01`; accept in the following cycle.
  - A request with `BO[0]=1` on the same field is accepted immediately.
- Same-cycle `pend_set=pend_clr=0x80` on field 7: the bit remains set and a request on field 7 stalls.
- Assert `rst_n=0` while a request is stalled: next cycle `pend=0`, `CTR=0`, `res_valid=0`.
